// File: rtl/scoreboard_timer_core.sv
// ----------------------------------------------------------------------------
// scoreboard_timer_core: per-team BCD scores, BCD mm:ss countdown and buzzer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scoreboard_timer_core #(
  parameter int NUM_TEAMS    = 2,
  parameter int TEAM_W       = 1,
  parameter int SCORE_DIGITS = 3,
  parameter int TICK_DIV     = 100000000,
  parameter int GAME_MINUTES = 12,
  parameter int BUZZ_CYCLES  = 50000000
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic                                reset_points_i,
  input  logic                                reset_score_i,
  input  logic [TEAM_W-1:0]                   team_i,
  input  logic                                one_point_i,
  input  logic                                two_point_i,
  input  logic                                three_point_i,
  input  logic                                minus_point_i,
  input  logic                                start_i,
  input  logic                                pause_i,
  output logic [NUM_TEAMS*SCORE_DIGITS*4-1:0] score_bcd_o,
  output logic [7:0]                          minutes_bcd_o,
  output logic [7:0]                          seconds_bcd_o,
  output logic [1:0]                          timer_state_o,
  output logic                                buzzer_o
);

  localparam int SW  = SCORE_DIGITS * 4;
  localparam int SBW = NUM_TEAMS * SW;
  localparam int PW  = $clog2(TICK_DIV);
  localparam int BW  = $clog2(BUZZ_CYCLES + 1);
  localparam logic [7:0]    GM_BCD    = 8'(((GAME_MINUTES / 10) * 16) + (GAME_MINUTES % 10));
  localparam logic [SW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Button bit order: 0 one, 1 two, 2 three, 3 minus, 4 start
  logic [4:0]     btn_q1_q, btn_q2_q;
  logic [4:0]     w_edge;
  logic [SBW-1:0] score_q, score_d;
  logic [3:0]     w_amt;
  logic           w_minus;
  logic           w_team_ok;

  state_t         state_q;
  logic [PW-1:0]  presc_q;
  logic [7:0]     minutes_q, seconds_q;
  logic [7:0]     w_min_next, w_sec_next;
  logic           w_tick;
  logic           buzzer_q;
  logic [BW-1:0]  buzz_cnt_q;

  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] v, input logic [3:0] amt);
    logic [SW-1:0] r;
    logic [4:0]    s;
    logic [3:0]    c;
    r = '0;
    c = amt;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      s = {1'b0, v[i*4 +: 4]} + {1'b0, c};
      if (s > 5'd9) begin
        r[i*4 +: 4] = 4'(s - 5'd10);
        c           = 4'd1;
      end else begin
        r[i*4 +: 4] = s[3:0];
        c           = 4'd0;
      end
    end
    // A carry out of the top digit means the score would wrap: pin it instead
    if (c != 4'd0) r = ALL_NINES;
    return r;
  endfunction

  function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    if (v != '0) begin
      for (int i = 0; i < SCORE_DIGITS; i++) begin
        if (b) begin
          if (v[i*4 +: 4] == 4'd0) begin
            r[i*4 +: 4] = 4'd9;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
            b           = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign w_edge    = btn_q1_q & ~btn_q2_q;
  assign w_team_ok = ({1'b0, team_i} < (TEAM_W+1)'(NUM_TEAMS));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      btn_q1_q <= '0;
      btn_q2_q <= '0;
      score_q  <= '0;
    end else begin
      btn_q1_q <= {start_i, minus_point_i, three_point_i, two_point_i, one_point_i};
      btn_q2_q <= btn_q1_q;
      score_q  <= score_d;
    end
  end

  always_comb begin
    w_amt   = 4'd0;
    w_minus = 1'b0;
    score_d = score_q;
    if (w_edge[2])      w_amt   = 4'd3;
    else if (w_edge[1]) w_amt   = 4'd2;
    else if (w_edge[0]) w_amt   = 4'd1;
    else if (w_edge[3]) w_minus = 1'b1;
    if (reset_points_i) begin
      score_d = '0;
    end else if (w_team_ok) begin
      for (int t = 0; t < NUM_TEAMS; t++) begin
        if (32'(team_i) == 32'(t)) begin
          if (w_amt != 4'd0)  score_d[t*SW +: SW] = bcd_add(score_q[t*SW +: SW], w_amt);
          else if (w_minus)   score_d[t*SW +: SW] = bcd_dec(score_q[t*SW +: SW]);
        end
      end
    end
  end

  always_comb begin
    w_min_next = minutes_q;
    w_sec_next = seconds_q;
    if (seconds_q != 8'h00) begin
      w_sec_next = (seconds_q[3:0] == 4'd0) ? {seconds_q[7:4] - 4'd1, 4'd9}
                                            : {seconds_q[7:4], seconds_q[3:0] - 4'd1};
    end else if (minutes_q != 8'h00) begin
      w_sec_next = 8'h59;
      w_min_next = (minutes_q[3:0] == 4'd0) ? {minutes_q[7:4] - 4'd1, 4'd9}
                                            : {minutes_q[7:4], minutes_q[3:0] - 4'd1};
    end
  end

  assign w_tick = (state_q == ST_RUN) && !pause_i && (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      minutes_q  <= GM_BCD;
      seconds_q  <= 8'h00;
      buzzer_q   <= 1'b0;
      buzz_cnt_q <= '0;
    end else begin
      if (buzzer_q) begin
        if (buzz_cnt_q == '0) buzzer_q   <= 1'b0;
        else                  buzz_cnt_q <= buzz_cnt_q - BW'(1);
      end
      if (reset_score_i) begin
        state_q   <= ST_IDLE;
        presc_q   <= '0;
        minutes_q <= GM_BCD;
        seconds_q <= 8'h00;
        buzzer_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            presc_q <= '0;
            if (w_edge[4] && !pause_i) state_q <= ST_RUN;
          end
          ST_RUN: begin
            if (pause_i) begin
              state_q <= ST_PAUSED;
            end else if (w_tick) begin
              presc_q   <= '0;
              minutes_q <= w_min_next;
              seconds_q <= w_sec_next;
              if ({w_min_next, w_sec_next} == 16'h0000) begin
                state_q    <= ST_EXPIRED;
                buzzer_q   <= 1'b1;
                buzz_cnt_q <= BW'(BUZZ_CYCLES - 1);
              end
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          ST_PAUSED: begin
            if (!pause_i) state_q <= ST_RUN;
          end
          default: begin
            presc_q <= '0;
          end
        endcase
      end
    end
  end

  assign score_bcd_o   = score_q;
  assign minutes_bcd_o = minutes_q;
  assign seconds_bcd_o = seconds_q;
  assign timer_state_o = state_q;
  assign buzzer_o      = buzzer_q;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_timer_core.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_timer_core: directed self-checking bench for scoreboard_timer_core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scoreboard_timer_core;

  localparam int B_ONE   = 0;
  localparam int B_TWO   = 1;
  localparam int B_THREE = 2;
  localparam int B_MINUS = 3;
  localparam int B_START = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_points, rst_score;
  logic [1:0]  team;
  logic        one, two, three, minus, start, pause;
  logic [15:0] score;
  logic [7:0]  mins, secs;
  logic [1:0]  state;
  logic        buzz;

  int n_checks = 0;
  int n_fail   = 0;

  scoreboard_timer_core #(
    .NUM_TEAMS(2), .TEAM_W(2), .SCORE_DIGITS(2),
    .TICK_DIV(4), .GAME_MINUTES(1), .BUZZ_CYCLES(3)
  ) dut (
    .clock_i(clk), .reset_i(rst), .reset_points_i(rst_points), .reset_score_i(rst_score),
    .team_i(team), .one_point_i(one), .two_point_i(two), .three_point_i(three),
    .minus_point_i(minus), .start_i(start), .pause_i(pause),
    .score_bcd_o(score), .minutes_bcd_o(mins), .seconds_bcd_o(secs),
    .timer_state_o(state), .buzzer_o(buzz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_ONE:   one   = v;
      B_TWO:   two   = v;
      B_THREE: three = v;
      B_MINUS: minus = v;
      default: start = v;
    endcase
  endtask

  // One-cycle pulse, then enough idle cycles for the action to land.
  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(1);
    set_btn(b, 1'b0);
    cyc(3);
  endtask

  initial begin
    rst = 1'b1; rst_points = 1'b0; rst_score = 1'b0; team = 2'd0;
    one = 1'b0; two = 1'b0; three = 1'b0; minus = 1'b0; start = 1'b0; pause = 1'b0;
    cyc(2);
    check("rst_score", 32'(score), 32'h0000);
    check("rst_min",   32'(mins),  32'h01);
    check("rst_sec",   32'(secs),  32'h00);
    check("rst_state", 32'(state), 32'd0);
    check("rst_buzz",  32'(buzz),  32'd0);
    rst = 1'b0;
    cyc(1);

    // Held award: one action, two-edge latency
    team = 2'd0; one = 1'b1;
    cyc(1);
    check("lat_edge1", 32'(score), 32'h0000);
    cyc(1);
    check("lat_edge2", 32'(score), 32'h0001);
    cyc(8);
    check("hold_once", 32'(score), 32'h0001);
    one = 1'b0;
    cyc(2);

    // Priority: three beats two on the same cycle
    team = 2'd1; two = 1'b1; three = 1'b1;
    cyc(1);
    two = 1'b0; three = 1'b0;
    cyc(3);
    check("prio_3_over_2", 32'(score), 32'h0301);
    press(B_MINUS);
    check("minus_t1", 32'(score), 32'h0201);
    team = 2'd0;
    press(B_MINUS);
    check("minus_t0", 32'(score), 32'h0200);
    press(B_MINUS);
    check("minus_at_0", 32'(score), 32'h0200);
    team = 2'd3;
    press(B_ONE);
    check("bad_team", 32'(score), 32'h0200);

    // Saturation with two BCD digits
    team = 2'd0;
    for (int i = 0; i < 32; i++) begin
      three = 1'b1; cyc(1);
      three = 1'b0; cyc(1);
    end
    press(B_TWO);
    check("reach_98", 32'(score), 32'h0298);
    press(B_THREE);
    check("sat_98p3", 32'(score), 32'h0299);
    press(B_ONE);
    check("sat_99p1", 32'(score), 32'h0299);
    rst_points = 1'b1; one = 1'b1;
    cyc(1);
    check("rp_clear", 32'(score), 32'h0000);
    one = 1'b0;
    cyc(1);
    rst_points = 1'b0;
    cyc(3);
    check("rp_beats_award", 32'(score), 32'h0000);

    // Full countdown to expiry and buzzer
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    check("run_enter", 32'(state), 32'd1);
    cyc(3);
    check("pre_tick_sec", 32'(secs), 32'h00);
    cyc(1);
    check("tick1_sec", 32'(secs), 32'h59);
    check("tick1_min", 32'(mins), 32'h00);
    cyc(235);
    check("last_sec_state", 32'(state), 32'd1);
    check("last_sec", 32'(secs), 32'h01);
    cyc(1);
    check("exp_state", 32'(state), 32'd3);
    check("exp_time", 32'({mins, secs}), 32'h0000);
    check("buzz_c1", 32'(buzz), 32'd1);
    cyc(1);
    check("buzz_c2", 32'(buzz), 32'd1);
    cyc(1);
    check("buzz_c3", 32'(buzz), 32'd1);
    cyc(1);
    check("buzz_off", 32'(buzz), 32'd0);
    press(B_START);
    check("start_in_exp", 32'(state), 32'd3);
    check("start_in_exp_buzz", 32'(buzz), 32'd0);
    rst_score = 1'b1; cyc(1); rst_score = 1'b0;
    check("rs_state", 32'(state), 32'd0);
    check("rs_time", 32'({mins, secs}), 32'h0100);

    // Pause preserves the partial second
    start = 1'b1; cyc(1); start = 1'b0; cyc(1);
    cyc(2);
    pause = 1'b1;
    cyc(1);
    check("paused_state", 32'(state), 32'd2);
    cyc(19);
    check("paused_hold_state", 32'(state), 32'd2);
    check("paused_time", 32'({mins, secs}), 32'h0100);
    pause = 1'b0;
    cyc(1);
    check("resume_state", 32'(state), 32'd1);
    cyc(1);
    check("resume_c1", 32'({mins, secs}), 32'h0100);
    cyc(1);
    check("resume_tick", 32'({mins, secs}), 32'h0059);
    rst_score = 1'b1; cyc(1); rst_score = 1'b0;
    check("rs2_state", 32'(state), 32'd0);
    pause = 1'b1;
    press(B_START);
    pause = 1'b0;
    cyc(2);
    check("start_while_pause", 32'(state), 32'd0);

    // Asynchronous reset mid-run
    team = 2'd0;
    press(B_ONE);
    check("pre_arst_score", 32'(score), 32'h0001);
    press(B_START);
    cyc(5);
    check("pre_arst_min", 32'(mins), 32'h00);
    #2 rst = 1'b1;
    #1;
    check("arst_score", 32'(score), 32'h0000);
    check("arst_state", 32'(state), 32'd0);
    check("arst_time", 32'({mins, secs}), 32'h0100);
    check("arst_buzz", 32'(buzz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);
    check("post_arst_state", 32'(state), 32'd0);
    check("post_arst_time", 32'({mins, secs}), 32'h0100);
    check("post_arst_score", 32'(score), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
